ir_encoder_tx: RTL and testbench
================================

IR_ENCODER_TX -- requirements
Module: ir_encoder_tx

Interface
REQ-001 SHALL have parameter T0_TICKS, default 441: rising-edge-to-rising-edge period of a '0' bit, in enable ticks.
REQ-002 SHALL have parameter T1_TICKS, default 890: period of a '1' bit, in enable ticks.
REQ-003 SHALL have parameter START_TICKS, default 2002: period of the start symbol, in enable ticks.
REQ-004 SHALL have parameter MARK_TICKS, default 140: low-pulse width that ends every symbol, in enable ticks.
REQ-005 SHALL have parameter GUARD_TICKS, default 4096: post-frame idle time, in enable ticks; used only with IR_TX_GUARD_EN.
REQ-006 SHALL have port clk  input  1: clock.
REQ-007 SHALL have port rst  input  1: reset, asynchronous, active-high.
REQ-008 SHALL have port enable  input  1: timebase tick; all timing advances only on clk edges with enable=1.
REQ-009 SHALL have port start  input  1: frame request, sampled on every clk edge.
REQ-010 SHALL have port command  input  32: frame payload, captured on start acceptance.
REQ-011 SHALL have port busy  output  1: frame in progress.
REQ-012 SHALL have port done  output  1: one-clk pulse at frame completion.
REQ-013 SHALL have port ir_output  output  1: IR line, idle high, registered.

Function
REQ-014 SHALL implement states IDLE, SYNC, SPACE, MARK and GUARD (GUARD present only with IR_TX_GUARD_EN).
REQ-015 In IDLE, start=1 SHALL, on that clk edge and regardless of enable:
- latch command into a 32-bit shift register;
- clear the symbol counter (6 bits) and the tick counter (13 bits);
- set busy=1 and ir_output=0;
- enter SYNC.
REQ-016 start while not IDLE SHALL be ignored, and command changes after acceptance SHALL NOT affect the frame.
REQ-017 SYNC SHALL hold ir_output=0 for MARK_TICKS enable ticks, then drive ir_output=1 and enter SPACE with symbol 0. This rising edge is the frame's timing reference.
REQ-018 Symbol 0 SHALL be the start symbol with period START_TICKS. Symbols 1..32 SHALL be command bits, LSB first, with period T1_TICKS for a 1 and T0_TICKS for a 0.
REQ-019 SPACE SHALL hold ir_output=1 for (period - MARK_TICKS) enable ticks, then drive ir_output=0 and enter MARK.
REQ-020 MARK SHALL hold ir_output=0 for MARK_TICKS enable ticks, then drive ir_output=1, so consecutive rising edges are exactly one symbol period apart.
REQ-021 On each MARK exit, the symbol counter SHALL increment; for bit symbols, the shift register SHALL shift right one place.
REQ-022 On MARK exit of symbol 32, the block SHALL end the frame (33 rising edges after the reference edge, 34 in total):
- without IR_TX_GUARD_EN: go to IDLE with busy=0 and done=1 for one clk;
- with IR_TX_GUARD_EN: go to GUARD.
REQ-023 With enable=0, all states, counters and ir_output SHALL hold; done SHALL NOT assert.
REQ-024 A tick counter reaching its terminal value SHALL reload to 0 in the same cycle it changes state; it SHALL never wrap mid-state.
REQ-025 done SHALL be registered and SHALL be 0 in every cycle except the completion cycle.

Reset
REQ-026 While rst=1, the block SHALL immediately force ir_output=1, busy=0, done=0, state=IDLE, and clear all counters and the shift register.
REQ-027 rst mid-frame SHALL abort the frame without asserting done; the first start after reset release SHALL begin a fresh frame.

Configuration
REQ-028 With macro IR_TX_GUARD_EN defined, GUARD SHALL hold ir_output=1 and busy=1 for GUARD_TICKS enable ticks, then go to IDLE with busy=0 and done=1 for one clk; start is ignored during GUARD.
REQ-029 Without IR_TX_GUARD_EN, GUARD and its counter logic SHALL NOT be synthesized, and done SHALL pulse at the final MARK exit.

Verification
REQ-030 enable=1 constantly, command=0x00000001:
- ir_output falls on the start clk;
- the reference rising edge follows 140 clks later;
- then rising-edge intervals of 2002, 890, and 31x441 clks;
- done pulses once, on the final rise clk.
REQ-031 command=0xA5A5F00F, enable=1 every 4th clk: the 32 bit intervals, divided by 4, decode LSB first to 0xA5A5F00F, and the start interval is 8008 clks.
REQ-032 A second start at symbol 10 with command=0xFFFFFFFF: the frame still carries the originally latched value, with no restart, and busy stays high continuously.
REQ-033 rst asserted during symbol 20 MARK: ir_output=1 asynchronously, busy=0, no done pulse; a start after release gives a correct full frame.
REQ-034 IR_TX_GUARD_EN defined:
- done occurs 4096 enable ticks after the final rising edge;
- start during GUARD is ignored;
- start 1 clk after done is accepted.

Source files
------------

// File: rtl/ir_encoder_tx.sv
// ir_encoder_tx: pulse-distance IR frame transmitter.
// A frame is a 140-tick sync low pulse, then a start symbol and 32 command bits
// (LSB first). Each symbol is a high space followed by a fixed low mark, so the
// rising edges are exactly one symbol period apart.
// Optional feature: define IR_TX_GUARD_EN to add a post-frame GUARD idle state
// before done is raised.
module ir_encoder_tx #(
   parameter int T0_TICKS    = 441,
   parameter int T1_TICKS    = 890,
   parameter int START_TICKS = 2002,
   parameter int MARK_TICKS  = 140,
   parameter int GUARD_TICKS = 4096
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic        start,
   input  logic [31:0] command,
   output logic        busy,
   output logic        done,
   output logic        ir_output
);

   // All tick periods share one 13-bit counter, so they must fit in it.
   if (MARK_TICKS < 1 || T0_TICKS <= MARK_TICKS || T1_TICKS <= MARK_TICKS ||
       START_TICKS <= MARK_TICKS || T0_TICKS > 8192 || T1_TICKS > 8192 ||
       START_TICKS > 8192 || GUARD_TICKS < 1 || GUARD_TICKS > 8192) begin : g_bad_params
      $error("ir_encoder_tx: tick parameters out of range");
   end

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SYNC  = 3'd1,
      S_SPACE = 3'd2,
      S_MARK  = 3'd3
`ifdef IR_TX_GUARD_EN
      , S_GUARD = 3'd4
`endif
   } state_t;

   localparam logic [12:0] MARK_LAST = 13'(MARK_TICKS - 1);
   localparam logic [12:0] MARK_W    = 13'(MARK_TICKS);
   localparam logic [12:0] T0_W      = 13'(T0_TICKS);
   localparam logic [12:0] T1_W      = 13'(T1_TICKS);
   localparam logic [12:0] START_W   = 13'(START_TICKS);
`ifdef IR_TX_GUARD_EN
   localparam logic [12:0] GUARD_LAST = 13'(GUARD_TICKS - 1);
`endif

   state_t      state_q, state_d;
   logic [12:0] tick_q, tick_d;
   logic [5:0]  sym_q, sym_d;
   logic [31:0] shreg_q, shreg_d;
   logic        ir_q, ir_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic [12:0] period;
   logic [12:0] space_last;

   // Period of the current symbol: symbol 0 is the start symbol, the rest are
   // data bits taken from the low end of the shift register.
   always_comb begin
      period = T0_W;
      if (sym_q == 6'd0) begin
         period = START_W;
      end else if (shreg_q[0]) begin
         period = T1_W;
      end
      space_last = period - MARK_W - 13'd1;
   end

   // Next-state and registered-output logic; nothing moves without enable
   // except accepting a start in IDLE.
   always_comb begin
      state_d = state_q;
      tick_d  = tick_q;
      sym_d   = sym_q;
      shreg_d = shreg_q;
      ir_d    = ir_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               shreg_d = command;
               tick_d  = '0;
               sym_d   = '0;
               busy_d  = 1'b1;
               ir_d    = 1'b0;
               state_d = S_SYNC;
            end
         end
         S_SYNC: begin
            if (enable) begin
               if (tick_q == MARK_LAST) begin
                  tick_d  = '0;
                  sym_d   = '0;
                  ir_d    = 1'b1;
                  state_d = S_SPACE;
               end else begin
                  tick_d = tick_q + 13'd1;
               end
            end
         end
         S_SPACE: begin
            if (enable) begin
               if (tick_q == space_last) begin
                  tick_d  = '0;
                  ir_d    = 1'b0;
                  state_d = S_MARK;
               end else begin
                  tick_d = tick_q + 13'd1;
               end
            end
         end
         S_MARK: begin
            if (enable) begin
               if (tick_q == MARK_LAST) begin
                  tick_d = '0;
                  ir_d   = 1'b1;
                  sym_d  = sym_q + 6'd1;
                  if (sym_q != 6'd0) begin
                     shreg_d = shreg_q >> 1;
                  end
                  if (sym_q == 6'd32) begin
`ifdef IR_TX_GUARD_EN
                     state_d = S_GUARD;
`else
                     state_d = S_IDLE;
                     busy_d  = 1'b0;
                     done_d  = 1'b1;
`endif
                  end else begin
                     state_d = S_SPACE;
                  end
               end else begin
                  tick_d = tick_q + 13'd1;
               end
            end
         end
`ifdef IR_TX_GUARD_EN
         S_GUARD: begin
            if (enable) begin
               if (tick_q == GUARD_LAST) begin
                  tick_d  = '0;
                  state_d = S_IDLE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  tick_d = tick_q + 13'd1;
               end
            end
         end
`endif
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers; reset forces the idle line level at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         tick_q  <= '0;
         sym_q   <= '0;
         shreg_q <= '0;
         ir_q    <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         tick_q  <= tick_d;
         sym_q   <= sym_d;
         shreg_q <= shreg_d;
         ir_q    <= ir_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign ir_output = ir_q;

endmodule

// File: tb/tb_ir_encoder_tx.sv
// Bench for ir_encoder_tx with scaled-down tick parameters.
module tb_ir_encoder_tx;

   localparam int T0 = 10;
   localparam int T1 = 18;
   localparam int ST = 30;
   localparam int MK = 4;
   localparam int GD = 40;
`ifdef IR_TX_GUARD_EN
   localparam bit GUARD_ON = 1'b1;
`else
   localparam bit GUARD_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic        start;
   logic [31:0] command;
   logic        busy;
   logic        done;
   logic        ir_output;

   always #5 clk = ~clk;

   ir_encoder_tx #(
      .T0_TICKS(T0), .T1_TICKS(T1), .START_TICKS(ST),
      .MARK_TICKS(MK), .GUARD_TICKS(GD)
   ) dut (
      .clk(clk), .rst(rst), .enable(enable), .start(start),
      .command(command), .busy(busy), .done(done), .ir_output(ir_output)
   );

   int passed = 0;
   int total  = 0;

   task automatic check(input string name, input longint act, input longint exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d, required %0d", name, act, exp);
   endtask

   // Scoreboard: expected rise gaps and the done gap, in clk cycles.
   typedef struct {
      bit     is_done;
      longint gap;
   } ev_t;
   ev_t exp_q[$];

   task automatic pop_check(input bit is_done, input longint gap);
      ev_t e;
      if (exp_q.size() == 0) begin
         total++;
         $display("FAIL unexpected_event: got kind=%0d gap=%0d, required no event", is_done, gap);
      end else begin
         e = exp_q.pop_front();
         check("event_kind", is_done, e.is_done);
         if (is_done == e.is_done) check(is_done ? "done_gap" : "rise_gap", gap, e.gap);
      end
   endtask

   task automatic push_frame(input logic [31:0] c, input int d);
      exp_q.push_back('{1'b0, MK * d});
      exp_q.push_back('{1'b0, ST * d});
      for (int i = 0; i < 32; i++) exp_q.push_back('{1'b0, (c[i] ? T1 : T0) * d});
      exp_q.push_back('{1'b1, GUARD_ON ? GD * d : 0});
   endtask

   // Monitor, sampling on the falling edge.
   longint cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   bit     mon_en = 1'b0;
   logic   prev_ir = 1'b1;
   logic   prev_busy = 1'b0;
   longint last_cyc = 0;
   longint frame_start = 0;
   longint frame_len = 0;
   int     rise_cnt = 0;

   always @(negedge clk) begin
      if (mon_en) begin
         if (busy && !prev_busy) begin
            last_cyc    = cyc;
            frame_start = cyc;
            rise_cnt    = 0;
         end
         if (ir_output && !prev_ir) begin
            rise_cnt++;
            if (rise_cnt == 34) frame_len = cyc - frame_start;
            pop_check(1'b0, cyc - last_cyc);
            last_cyc = cyc;
         end
         if (done) pop_check(1'b1, cyc - last_cyc);
         if (!busy && prev_busy) check("busy_fall_with_done", done, 1);
      end
      prev_ir   = ir_output;
      prev_busy = busy;
   end

   // Stimulus: enable is high on every div-th edge after the start edge.
   int div = 1;
   int k = 0;

   task automatic step();
      @(posedge clk);
      #1;
      k++;
      enable = (((k + 1) % div) == 0);
   endtask

   task automatic start_frame(input logic [31:0] c);
      command = c;
      start   = 1'b1;
      @(posedge clk);
      #1;
      start   = 1'b0;
      command = ~c;
      k       = 0;
      enable  = ((1 % div) == 0);
   endtask

   task automatic wait_done(input int budget);
      for (int n = 0; n < budget && !done; n++) step();
      check("done_seen", done, 1);
      @(negedge clk);
      #1;
   endtask

   task automatic wait_rise(input int n, input int budget);
      for (int i = 0; i < budget && rise_cnt < n; i++) step();
      check("rise_reached", rise_cnt >= n, 1);
   endtask

   typedef struct {
      logic [31:0] cmd;
      int          d;
      longint      len;
   } vec_t;
   vec_t vecs[5];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, required $finish");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{32'h00000001, 1, 362};
      vecs[1] = '{32'hA5A5F00F, 4, 1928};
      vecs[2] = '{32'h00000000, 1, 354};
      vecs[3] = '{32'hFFFFFFFF, 2, 1220};
      vecs[4] = '{32'h12345678, 3, 1374};

      rst = 1'b1; enable = 1'b1; start = 1'b1; command = 32'hDEADBEEF;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ir", ir_output, 1);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      start = 1'b0;
      rst   = 1'b0;
      step();
      check("idle_ir", ir_output, 1);
      check("idle_busy", busy, 0);
      mon_en = 1'b1;

      // Table frames, issued back to back right after each done.
      for (int i = 0; i < 5; i++) begin
         div = vecs[i].d;
         push_frame(vecs[i].cmd, div);
         start_frame(vecs[i].cmd);
         check("busy_after_start", busy, 1);
         check("ir_low_after_start", ir_output, 0);
         wait_done(20000);
         check("frame_len", frame_len, vecs[i].len);
         check("queue_drained", exp_q.size(), 0);
      end

      // Second start during symbol 10 must not restart or alter the frame.
      div = 1;
      push_frame(32'h0000F0F3, 1);
      start_frame(32'h0000F0F3);
      wait_rise(11, 2000);
      command = 32'hFFFFFFFF;
      start   = 1'b1;
      step();
      start   = 1'b0;
      check("busy_after_restart_try", busy, 1);
      wait_done(4000);
      check("restart_frame_len", frame_len, 434);
      check("restart_queue_drained", exp_q.size(), 0);

      // Reset during the symbol-20 mark aborts the frame without done.
      push_frame(32'h12345678, 1);
      start_frame(32'h12345678);
      wait_rise(21, 2000);
      for (int i = 0; i < 100 && ir_output; i++) step();
      check("in_mark20", ir_output, 0);
      @(negedge clk);
      #2;
      mon_en = 1'b0;
      rst    = 1'b1;
      #1;
      check("abort_ir_async", ir_output, 1);
      check("abort_busy_async", busy, 0);
      check("abort_done", done, 0);
      repeat (2) step();
      check("abort_done_held", done, 0);
      exp_q.delete();
      rst = 1'b0;
      step();
      mon_en = 1'b1;
      push_frame(32'h12345678, 1);
      start_frame(32'h12345678);
      wait_done(4000);
      check("post_reset_frame_len", frame_len, 458);
      check("post_reset_queue_drained", exp_q.size(), 0);

`ifdef IR_TX_GUARD_EN
      // Start during GUARD is ignored; start right after done is accepted.
      push_frame(32'h0000000F, 1);
      start_frame(32'h0000000F);
      wait_rise(34, 2000);
      repeat (5) step();
      command = 32'h0;
      start   = 1'b1;
      step();
      start   = 1'b0;
      check("guard_busy", busy, 1);
      check("guard_ir", ir_output, 1);
      wait_done(200);
      check("guard_queue_drained", exp_q.size(), 0);
      push_frame(32'h00000003, 1);
      start_frame(32'h00000003);
      check("guard_next_accepted", busy, 1);
      wait_done(4000);
      check("guard_next_len", frame_len, 4 + 30 + 2 * 18 + 30 * 10);
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
